// File: rtl/mux_4_arbiter_if.sv
// rtl/mux_4_arbiter_if.sv - request/data/handshake bundle shared by the arbiter and its users
// Ports: req[3:0], a/b/c/d data channels, out_ready (driven by the requester side);
//        gnt[3:0], sel[1:0], out, out_valid, busy (driven by the arbiter).
interface mux_4_arbiter_if #(
    parameter int DATA_W = 4
);
    logic [3:0]        req;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
    logic [DATA_W-1:0] d;
    logic              out_ready;
    logic [3:0]        gnt;
    logic [1:0]        sel;
    logic [DATA_W-1:0] out;
    logic              out_valid;
    logic              busy;

    modport master (
        output req, a, b, c, d, out_ready,
        input  gnt, sel, out, out_valid, busy
    );

    modport slave (
        input  req, a, b, c, d, out_ready,
        output gnt, sel, out, out_valid, busy
    );
endinterface

// File: rtl/mux_4_arbiter.sv
// rtl/mux_4_arbiter.sv - round-robin arbiter sharing a 4:1 data select with a hold limit per grant
// Ports: clk, rst (synchronous, active-high); bus (slave modport): req, a..d, out_ready in;
//        gnt (one-hot, registered), sel (registered), out (combinational mux), out_valid, busy out.
module mux_4_arbiter #(
    parameter int DATA_W   = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    mux_4_arbiter_if.slave    bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t      state_q, state_n;
    logic [3:0]  gnt_q, gnt_n;
    logic [1:0]  sel_q, sel_n;
    logic [1:0]  last_q, last_n;
    logic [7:0]  hold_q, hold_n;

    logic        out_valid;
    logic        xfer;
    logic        at_limit;
    logic        others;
    logic [3:0]  mask;
    logic [1:0]  win;
    logic [DATA_W-1:0] out_mux;

    // First set bit of mask in the order last+1, last+2, last+3, last.
    // Scanning from the lowest priority up lets the highest priority hit overwrite.
    function automatic logic [1:0] rr_pick(input logic [3:0] m, input logic [1:0] last_v);
        logic [1:0] idx;
        logic [1:0] w;
        w = last_v;
        for (int k = 4; k >= 1; k--) begin
            idx = last_v + 2'(k);
            if (m[idx]) w = idx;
        end
        return w;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b00;
            last_q  <= 2'd3;
            hold_q  <= 8'd0;
        end else begin
            state_q <= state_n;
            gnt_q   <= gnt_n;
            sel_q   <= sel_n;
            last_q  <= last_n;
            hold_q  <= hold_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        gnt_n    = gnt_q;
        sel_n    = sel_q;
        last_n   = last_q;
        hold_n   = hold_q;
        xfer     = 1'b0;
        at_limit = (hold_q == HOLD_LAST);
        others   = |(bus.req & ~gnt_q);
        mask     = 4'b0000;
        win      = 2'b00;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    win     = rr_pick(bus.req, last_q);
                    state_n = GRANT;
                    gnt_n   = 4'b0001 << win;
                    sel_n   = win;
                    last_n  = win;
                    hold_n  = 8'd0;
                end
            end
            GRANT: begin
                xfer = out_valid && bus.out_ready;
                // Release when the owner is done, or when it has used its full
                // allowance and someone else is waiting.
                if (!bus.req[sel_q] || (xfer && at_limit && others)) begin
                    mask = bus.req & ~gnt_q;
                    if (|mask) begin
                        win     = rr_pick(mask, last_q);
                        gnt_n   = 4'b0001 << win;
                        sel_n   = win;
                        last_n  = win;
                        hold_n  = 8'd0;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = 4'b0000;
                        hold_n  = 8'd0;
                    end
                end else if (xfer) begin
                    // Nobody else waiting: restart the allowance without a bubble.
                    hold_n = at_limit ? 8'd0 : hold_q + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        out_mux = bus.a;
        case (sel_q)
            2'd0: out_mux = bus.a;
            2'd1: out_mux = bus.b;
            2'd2: out_mux = bus.c;
            2'd3: out_mux = bus.d;
            default: out_mux = bus.a;
        endcase
    end

    assign out_valid     = (state_q == GRANT) && bus.req[sel_q];
    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.out       = out_mux;
    assign bus.out_valid = out_valid;
    assign bus.busy      = (state_q == GRANT);
endmodule

// File: tb/tb_mux_4_arbiter.sv
// tb/tb_mux_4_arbiter.sv - scoreboard bench for mux_4_arbiter
module tb_mux_4_arbiter;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    int   tot [4];

    typedef struct packed {
        logic [1:0] ch;
        logic [3:0] dat;
    } exp_t;

    exp_t sb[$];

    mux_4_arbiter_if #(.DATA_W(4)) bus ();

    mux_4_arbiter #(.DATA_W(4), .MAX_HOLD(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every accepted handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            n_cmp++;
            if (!(bus.gnt == 4'b0000 || $onehot(bus.gnt))) begin
                n_fail++;
                $display("FAIL gnt_onehot: got %b", bus.gnt);
            end
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_xfer: got sel=%0d out=%h, none expected", bus.sel, bus.out);
                end else begin
                    e = sb.pop_front();
                    if (bus.sel !== e.ch || bus.out !== e.dat || bus.gnt !== (4'b0001 << e.ch)) begin
                        n_fail++;
                        $display("FAIL xfer: got sel=%0d out=%h gnt=%b, expected sel=%0d out=%h",
                                 bus.sel, bus.out, bus.gnt, e.ch, e.dat);
                    end
                end
                tot[bus.sel] = tot[bus.sel] + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push_n(input logic [1:0] ch, input logic [3:0] dat, input int n);
        exp_t e;
        e.ch  = ch;
        e.dat = dat;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic apply_reset();
        rst     = 1'b1;
        bus.req = 4'b0000;
        step();
        step();
        rst = 1'b0;
    endtask

    // Requester agent: each wanted channel holds req until it has had lim transfers.
    task automatic run_phase(input logic [3:0] want, input int l0, input int l1, input int l2,
                             input int l3, input int budget, output int idle, output int cyc);
        int lim [4];
        int base [4];
        bit all_done;
        bit started;
        lim = '{l0, l1, l2, l3};
        for (int i = 0; i < 4; i++) base[i] = tot[i];
        idle = 0;
        cyc  = 0;
        forever begin
            all_done = 1'b1;
            started  = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (tot[i] != base[i]) started = 1'b1;
                if (want[i] && (tot[i] - base[i] < lim[i])) begin
                    bus.req[i] = 1'b1;
                    all_done   = 1'b0;
                end else begin
                    bus.req[i] = 1'b0;
                end
            end
            if (all_done) break;
            if (started && !bus.busy) idle++;
            if (cyc >= budget) begin
                n_cmp++;
                n_fail++;
                $display("FAIL phase_timeout: got %0d cycles, limit %0d", cyc, budget);
                break;
            end
            step();
            cyc++;
        end
        bus.req = 4'b0000;
        step();
        step();
    endtask

    initial begin
        int idle;
        int cyc;
        int stuck;
        int base1;
        n_cmp  = 0;
        n_fail = 0;
        for (int i = 0; i < 4; i++) tot[i] = 0;
        rst           = 1'b1;
        bus.req       = 4'b0000;
        bus.a         = 4'h5;
        bus.b         = 4'h6;
        bus.c         = 4'h7;
        bus.d         = 4'h8;
        bus.out_ready = 1'b1;

        // Reset and idle
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            check("idle_gnt", {4'h0, bus.gnt}, 8'h00);
            check("idle_sel", {6'h0, bus.sel}, 8'h00);
            check("idle_busy", {7'h0, bus.busy}, 8'h00);
            check("idle_valid", {7'h0, bus.out_valid}, 8'h00);
            check("idle_out", {4'h0, bus.out}, 8'h05);
            step();
        end

        // Single requester on channel c
        apply_reset();
        bus.c = 4'hA;
        push_n(2'd2, 4'hA, 1);
        bus.req = 4'b0100;
        step();
        check("single_gnt", {4'h0, bus.gnt}, 8'h04);
        check("single_sel", {6'h0, bus.sel}, 8'h02);
        check("single_out", {4'h0, bus.out}, 8'h0A);
        check("single_valid", {7'h0, bus.out_valid}, 8'h01);
        step();
        bus.req = 4'b0000;
        step();
        check("single_rel_gnt", {4'h0, bus.gnt}, 8'h00);
        check("single_rel_busy", {7'h0, bus.busy}, 8'h00);
        check("single_rel_sel", {6'h0, bus.sel}, 8'h02);

        // All four request, two transfers each, direct handoffs
        apply_reset();
        bus.a = 4'h1; bus.b = 4'h2; bus.c = 4'h3; bus.d = 4'h4;
        push_n(2'd0, 4'h1, 2); push_n(2'd1, 4'h2, 2);
        push_n(2'd2, 4'h3, 2); push_n(2'd3, 4'h4, 2);
        run_phase(4'b1111, 2, 2, 2, 2, 100, idle, cyc);
        check("rr_idle", 8'(idle), 8'd0);
        check("rr_cycles", 8'(cyc), 8'd12);

        // Hold limit with two streaming requesters
        apply_reset();
        bus.a = 4'h6; bus.b = 4'h9;
        push_n(2'd0, 4'h6, 8); push_n(2'd1, 4'h9, 8); push_n(2'd0, 4'h6, 8);
        run_phase(4'b0011, 16, 8, 0, 0, 100, idle, cyc);
        check("hold_idle", 8'(idle), 8'd0);
        check("hold_cycles", 8'(cyc), 8'd25);

        // Lone streaming requester never loses the grant
        push_n(2'd0, 4'h6, 20);
        run_phase(4'b0001, 20, 0, 0, 0, 100, idle, cyc);
        check("lone_idle", 8'(idle), 8'd0);
        check("lone_cycles", 8'(cyc), 8'd21);

        // Backpressure while channel c owns the grant
        apply_reset();
        bus.a = 4'h8; bus.b = 4'h9; bus.c = 4'hC; bus.d = 4'hD;
        bus.out_ready = 1'b0;
        bus.req = 4'b0100;
        step();
        check("bp_gnt", {4'h0, bus.gnt}, 8'h04);
        bus.req = 4'b1111;
        stuck = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.gnt !== 4'b0100 || bus.sel !== 2'd2) stuck++;
        end
        check("bp_stall", 8'(stuck), 8'd0);
        bus.out_ready = 1'b1;
        push_n(2'd2, 4'hC, 8); push_n(2'd3, 4'hD, 2);
        push_n(2'd0, 4'h8, 2); push_n(2'd1, 4'h9, 2);
        run_phase(4'b1111, 2, 2, 8, 2, 100, idle, cyc);
        check("bp_idle", 8'(idle), 8'd0);
        check("bp_cycles", 8'(cyc), 8'd16);

        // Reset mid-grant
        apply_reset();
        bus.a = 4'hE; bus.b = 4'h3; bus.c = 4'h4; bus.d = 4'hB;
        push_n(2'd1, 4'h3, 3);
        base1 = tot[1];
        bus.req = 4'b0010;
        cyc = 0;
        while (tot[1] - base1 < 3 && cyc < 50) begin
            step();
            cyc++;
        end
        check("mid_xfers", 8'(tot[1] - base1), 8'd3);
        check("mid_gnt", {4'h0, bus.gnt}, 8'h02);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_gnt", {4'h0, bus.gnt}, 8'h00);
        check("rst_sel", {6'h0, bus.sel}, 8'h00);
        check("rst_busy", {7'h0, bus.busy}, 8'h00);
        push_n(2'd0, 4'hE, 1); push_n(2'd1, 4'h3, 1);
        push_n(2'd2, 4'h4, 1); push_n(2'd3, 4'hB, 1);
        run_phase(4'b1111, 1, 1, 1, 1, 100, idle, cyc);
        check("post_rst_idle", 8'(idle), 8'd0);
        check("post_rst_cycles", 8'(cyc), 8'd8);

        step();
        check("sb_drained", 8'(sb.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_4_arbiter.md
Name: mux_4_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one 4:1 select datapath (4 data channels, 2-bit select) between four requesters.
- Grants one channel at a time and drives the select code.
- Presents the selected channel's data to a single downstream consumer with a valid/ready handshake.
- Bounds each grant by a hold limit, so one streaming requester cannot starve the others.

Parameters:
- DATA_W, 4, width of each data channel and of the output.
- MAX_HOLD, 8, maximum accepted transfers per grant while another requester is waiting; legal range 1..255.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- req  input  4  request per channel; bit i = channel i (0=a,1=b,2=c,3=d)
- a  input  DATA_W  channel 0 data
- b  input  DATA_W  channel 1 data
- c  input  DATA_W  channel 2 data
- d  input  DATA_W  channel 3 data
- out_ready  input  1  downstream accepts data this cycle
- gnt  output  4  one-hot registered grant; all-zero when idle
- sel  output  2  registered select code of current owner
- out  output  DATA_W  data of channel sel (combinational from sel and inputs)
- out_valid  output  1  gnt nonzero AND req[owner]
- busy  output  1  registered; 1 while in GRANT state

Behaviour:
- One clock, clk. Reset is synchronous, active-high: rst sampled on the rising edge of clk.
- Reset values:
  - gnt=0000, sel=00, busy=0, out_valid=0.
  - hold_cnt=0, last=3, so channel 0 has first priority after reset.
  - out follows sel=00, i.e. shows a.
- States: IDLE, GRANT. Reset -> IDLE.
- Round-robin pick:
  - Search order is last+1, last+2, last+3, last (mod 4).
  - The first asserted req in a candidate mask wins.
  - last updates to the winner when a grant is issued.
- IDLE:
  - If req != 0: next cycle GRANT with gnt=onehot(winner), sel=winner, hold_cnt=0.
  - Grant latency is 1 cycle from req sample to gnt visible.
- GRANT:
  - Transfer occurs when out_valid && out_ready.
  - hold_cnt increments by 1 on each transfer; saturates at MAX_HOLD-1 is not needed because release or reset always happens first.
- Release conditions, evaluated each GRANT cycle; the result takes effect next cycle:
  - (R1) req[owner]=0: owner is done.
  - (R2) A transfer occurs, hold_cnt==MAX_HOLD-1, and any req[j]=1 with j!=owner.
- Hold limit reached with no other requester:
  - hold_cnt resets to 0.
  - Owner keeps the grant; no bubble.
- On release:
  - Candidate mask = req with the owner bit cleared.
  - If the mask is nonzero: direct handoff, next cycle GRANT to the RR winner, hold_cnt=0, no idle bubble.
  - If the mask is zero: next cycle IDLE, gnt=0, busy=0.
  - sel holds its last value in IDLE.
- Backpressure:
  - out_ready=0 holds owner, sel and hold_cnt.
  - out must stay stable only if the requester holds its input stable; the arbiter does not buffer data.
- A requester dropping req while out_ready=0 is legal and triggers R1. No transfer is counted that cycle.
- New requests arriving mid-grant never preempt. They are considered only at release.
- rst asserted in any state, mid-grant included:
  - Next edge returns all state to reset values.
  - Any in-flight handshake is abandoned.
- Invariants:
  - gnt is always one-hot or zero.
  - out_valid=1 implies gnt[sel]=1.

Test Plan:
- Reset, then req=0000 for 5 cycles -> gnt=0000, sel=00, busy=0, out_valid=0 every cycle.
- req=0100, c=4'hA, out_ready=1 -> gnt=0100, sel=10, out=A, out_valid=1 one cycle later. Drop req -> next cycle gnt=0000, busy=0.
- req=1111 held, out_ready=1, each requester drops req after 2 accepted transfers -> grant order 0,1,2,3 with direct handoffs, 2 transfers each, 0 idle cycles between owners.
- MAX_HOLD=8; req=0011 held, out_ready=1 -> channel 0 gets exactly 8 transfers, then channel 1 gets 8, then channel 0 again. req=0001 alone held for 20 cycles -> channel 0 never loses the grant.
- Channel 2 granted, out_ready=0 for 10 cycles with req=1111 -> gnt stays 0100, hold_cnt stays 0. out_ready=1 afterwards -> 8 transfers before handoff to channel 3.
- Channel 1 granted with 3 transfers done, rst=1 for one cycle -> next cycle gnt=0000, sel=00, busy=0. With req=1111, the first grant after rst is channel 0.
